mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-port memory arbiter between the pipeline's memory requesters (fetch, load/store, future DMA/debug ports) and the single shared memory port. Each requester uses the existing req/ack protocol; the arbiter selects one pending requester, registers its request, drives it downstream, and returns a one-cycle ack with registered read data. It replaces the fixed two-port fetch/mem arbitration with configurable port count and a fairness policy.

## Interface
- NPORTS, 2, number of requester ports (≥1)
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NPORTS  per-port request, held until ack
- addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW]
- write  in  NPORTS  per-port write (1) / read (0)
- wdata  in  NPORTS*DW  per-port store data
- width  in  NPORTS*2  per-port access width (byte/half/word)
- extend  in  NPORTS  per-port sign-extend for reads
- ack  out  NPORTS  one-hot, one-cycle completion pulse
- rdata  out  DW  read data, valid with ack
- m_req  out  1  downstream request
- m_addr  out  AW  downstream address
- m_write  out  1  downstream write
- m_wdata  out  DW  downstream store data
- m_width  out  2  downstream width
- m_extend  out  1  downstream extend
- m_ack  in  1  downstream completion
- m_rdata  in  DW  downstream read data, valid with m_ack

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req, pick grant g (policy below), latch addr/write/wdata/width/extend of port g into m_* registers, set m_req, store g → BUSY. No req → stay IDLE.
- BUSY: hold m_req and m_* stable; on m_ack clear m_req, register m_rdata into rdata, set ack[g] → RESP.
- RESP: ack[g]=1 for this cycle only; → IDLE. Requests are not sampled in RESP.
- Policy (see Configuration): round-robin from last grant+1, wrapping NPORTS-1 → 0; or fixed priority, lowest index wins.
- m_ack in IDLE or RESP: ignored.
- req[g] dropped during BUSY (protocol violation): transaction completes, ack[g] still pulses.
- NPORTS=1: grant always 0; policy irrelevant.
- Write transactions: rdata takes m_rdata anyway (don't-care for requester).

## Timing
- Reset values: state IDLE, m_req 0, all m_* 0, ack 0, rdata 0, last-grant pointer NPORTS-1 (port 0 has first priority).
- Reset mid-transaction: next cycle IDLE, m_req 0, no ack issued; outstanding m_ack ignored.
- req sampled cycle 0 → m_req high cycle 1 → m_ack earliest cycle 1 → ack/rdata cycle 2. Latency = 2 + memory wait cycles.
- Requester sees ack in cycle n and drops or re-issues req at edge ending n; next arbitration at cycle n+1 (IDLE). Back-to-back throughput: one transaction per 3 cycles minimum.
- m_* fields change only on the IDLE→BUSY edge.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; pointer updates to g on each grant.
- Undefined: fixed priority, lowest index; pointer register removed.

## Structure
- Shared package mem_pkg: width encodings (WIDTH_BYTE=0, WIDTH_HALF=1, WIDTH_WORD=2), arbiter state enum.
- Sub-module arb_select: combinational grant selection from req vector and last-grant pointer, one-hot and index outputs; mem_arbiter owns FSM and registers.

## Test plan
- Single read: NPORTS=2, port 1 req, addr 0x100, memory acks 1 cycle after m_req with 0xDEADBEEF → m_addr=0x100 in cycle 1, ack=2'b10 and rdata=0xDEADBEEF in cycle 3, single cycle.
- Contention RR (MEM_ARB_RR_EN): ports 0 and 1 both held continuously → grants alternate 0,1,0,1; no port granted twice while other pending.
- Contention fixed (macro undefined): NPORTS=4, ports 1 and 3 continuously requesting → port 1 granted every time, port 3 starved.
- Wrap: NPORTS=4 RR, last grant 3, ports 0 and 2 request → port 0 granted.
- Write + spurious ack: port 0 write 0x12345678 to 0x40 width WORD; m_ack pulsed in IDLE beforehand → ignored; m_wdata=0x12345678, m_write=1; ack[0] pulses once.
- Reset mid-BUSY: assert reset while m_req high → next cycle m_req=0, ack=0, state IDLE; subsequent m_ack produces no ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: definitions shared by the memory arbiter and its requesters.
//   - access width encodings carried on width / m_width
//   - arbiter FSM state type (also exported on the debug port)
//   - idx_width(): width of a port index for a given port count
package mem_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // A single port still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester-side and memory-side signals of
// the memory arbiter.
//   Requester side : req, addr, write, wdata, width, extend (to arbiter),
//                    ack, rdata (from arbiter). Port i fields sit at
//                    [i*AW +: AW], [i*DW +: DW], [i*2 +: 2].
//   Memory side    : m_req, m_addr, m_write, m_wdata, m_width, m_extend
//                    (from arbiter), m_ack, m_rdata (to arbiter).
// Handshake: a requester raises req[i] with stable fields and holds it until
// ack[i] pulses for exactly one cycle (rdata valid in that cycle). The
// arbiter holds m_req and all m_* fields stable until m_ack is seen; m_rdata
// is valid in the m_ack cycle.
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS-1:0]    write;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS*2-1:0]  width;
  logic [NPORTS-1:0]    extend;
  logic [NPORTS-1:0]    ack;
  logic [DW-1:0]        rdata;

  logic                 m_req;
  logic [AW-1:0]        m_addr;
  logic                 m_write;
  logic [DW-1:0]        m_wdata;
  logic [1:0]           m_width;
  logic                 m_extend;
  logic                 m_ack;
  logic [DW-1:0]        m_rdata;

  modport slave (
    input  req, addr, write, wdata, width, extend, m_ack, m_rdata,
    output ack, rdata, m_req, m_addr, m_write, m_wdata, m_width, m_extend
  );

  modport master (
    output req, addr, write, wdata, width, extend, m_ack, m_rdata,
    input  ack, rdata, m_req, m_addr, m_write, m_wdata, m_width, m_extend
  );
endinterface

// File: rtl/mem_arbiter_arb_select.sv
// arb_select: combinational grant selection for the memory arbiter.
//   req     : pending request vector
//   last    : index of the most recent grant (round-robin start point)
//   gnt_oh  : one-hot grant, all zero when nothing is pending
//   gnt_idx : index of the granted port
//   any     : at least one request pending
// Build option MEM_ARB_RR_EN: defined -> round-robin starting at last+1,
// wrapping NPORTS-1 -> 0; undefined -> fixed priority, lowest index wins
// and last is ignored.
module arb_select #(
  parameter int NPORTS = 2,
  parameter int IW     = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [NPORTS-1:0] gnt_oh,
  output logic [IW-1:0]     gnt_idx,
  output logic              any
);

`ifdef MEM_ARB_RR_EN
  // Rank each requester by its distance from last+1 (mod NPORTS); the
  // closest pending port wins.
  always_comb begin
    int best;
    int dist;
    best    = NPORTS;
    dist    = 0;
    gnt_idx = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (req[j]) begin
        dist = j - int'(last) - 1;
        if (dist < 0) dist = dist + NPORTS;
        if (dist < best) begin
          best    = dist;
          gnt_idx = IW'(j);
        end
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  // Scan from the top so the lowest pending index is written last.
  always_comb begin
    gnt_idx = '0;
    for (int j = NPORTS - 1; j >= 0; j--) begin
      if (req[j]) gnt_idx = IW'(j);
    end
  end
`endif

  assign any = |req;

  always_comb begin
    gnt_oh = '0;
    for (int j = 0; j < NPORTS; j++) begin
      gnt_oh[j] = any && (gnt_idx == IW'(j));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of a single shared memory port.
//   clk       : clock, everything on the rising edge
//   reset     : synchronous, active-high
//   bus       : mem_arbiter_if.slave (requester ports + downstream port)
//   dbg_state : current FSM state
// Flow: IDLE picks a pending port and registers its request onto m_*,
// BUSY waits for m_ack and registers m_rdata, RESP pulses ack[g] for one
// cycle. Requests are only sampled in IDLE, so throughput is at most one
// transaction every three cycles.
// Build option MEM_ARB_RR_EN: round-robin with a last-grant pointer;
// undefined gives fixed lowest-index priority with no pointer register.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output arb_state_e   dbg_state
);

  localparam int IW = idx_width(NPORTS);

  arb_state_e        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic              m_write_q, m_write_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic [1:0]        m_width_q, m_width_d;
  logic              m_extend_q, m_extend_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [IW-1:0]     gnt_q, gnt_d;

  logic [IW-1:0]     last_ptr;
  logic [NPORTS-1:0] sel_oh;
  logic [IW-1:0]     sel_idx;
  logic              sel_any;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] last_q, last_d;
  assign last_ptr = last_q;
`else
  assign last_ptr = '0;
`endif

  arb_select #(.NPORTS(NPORTS), .IW(IW)) u_sel (
    .req     (bus.req),
    .last    (last_ptr),
    .gnt_oh  (sel_oh),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_write_d  = m_write_q;
    m_wdata_d  = m_wdata_q;
    m_width_d  = m_width_q;
    m_extend_d = m_extend_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    gnt_d      = gnt_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          // m_* only ever change here, so they stay stable through BUSY.
          for (int j = 0; j < NPORTS; j++) begin
            if (sel_oh[j]) begin
              m_addr_d   = bus.addr[j*AW +: AW];
              m_write_d  = bus.write[j];
              m_wdata_d  = bus.wdata[j*DW +: DW];
              m_width_d  = bus.width[j*2 +: 2];
              m_extend_d = bus.extend[j];
            end
          end
          m_req_d = 1'b1;
          gnt_d   = sel_idx;
`ifdef MEM_ARB_RR_EN
          last_d  = sel_idx;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ack) begin
          m_req_d = 1'b0;
          // Captured for writes too; the requester ignores it then.
          rdata_d = bus.m_rdata;
          for (int j = 0; j < NPORTS; j++) begin
            ack_d[j] = (gnt_q == IW'(j));
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_write_q  <= 1'b0;
      m_wdata_q  <= '0;
      m_width_q  <= WIDTH_BYTE;
      m_extend_q <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
      // Pointing at the top port gives port 0 first priority.
      last_q     <= IW'(NPORTS - 1);
`endif
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_write_q  <= m_write_d;
      m_wdata_q  <= m_wdata_d;
      m_width_q  <= m_width_d;
      m_extend_q <= m_extend_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_write  = m_write_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_width  = m_width_q;
  assign bus.m_extend = m_extend_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with NPORTS=4.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge. A transaction-level model predicts every grant, the
// m_* fields, ack timing and rdata; directed tests add literal checks.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_e dbg_state;

  mem_arbiter_if #(.NPORTS(N), .AW(AW), .DW(DW)) bus();

  mem_arbiter #(.NPORTS(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [N+DW-1:0] exp_q[$];
  int glog[$];
  bit hold[N];
  int ack_cnt[N];
  bit auto_resp;
  int resp_wait;
  int cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    if (p < 0) return -1;
`ifdef MEM_ARB_RR_EN
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int first_bit(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] wd, input logic [1:0] wi, input logic ex);
    bus.addr[p*AW +: AW]  = a;
    bus.write[p]          = w;
    bus.wdata[p*DW +: DW] = wd;
    bus.width[p*2 +: 2]   = wi;
    bus.extend[p]         = ex;
    bus.req[p]            = 1'b1;
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (glog.size() < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (glog.size() < target) begin
      errors++;
      $display("FAIL %s_timeout: grants %0d need %0d", name, glog.size(), target);
    end
  endtask

  task automatic check_grant(input string name, input int idx, input int exp);
    if (glog.size() > idx) check(name, glog[idx], exp);
    else check(name, 64'hFFFF_FFFF_FFFF_FFFF, exp);
  endtask

  // Requesters: drop req after ack unless told to keep requesting.
  initial begin : requesters
    forever begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          ack_cnt[i]++;
          if (!hold[i]) bus.req[i] = 1'b0;
        end
      end
    end
  end

  // Memory: acks in the (resp_wait+1)-th cycle that m_req is seen high.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      tick();
      if (rst || !auto_resp) cnt = 0;
      else if (bus.m_ack) begin
        bus.m_ack = 1'b0;
        cnt = 0;
      end else if (bus.m_req) begin
        cnt++;
        if (cnt == resp_wait + 1) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = mem_val(bus.m_addr);
          cnt = 0;
        end
      end
    end
  end

  // Transaction-level model and per-cycle compare.
  initial begin : compare
    bit busy, pend, was_pend;
    int free_from, ptr, g;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_width;
    logic          e_write, e_extend;
    logic [N+DW-1:0] e;
    busy = 0; pend = 0; free_from = 0; ptr = N - 1; g = 0; cyc = 0;
    e_addr = '0; e_wdata = '0; e_width = '0; e_write = 0; e_extend = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 0; pend = 0; ptr = N - 1; free_from = cyc + 1;
        exp_q.delete();
      end else begin
        was_pend = pend;
        if (pend) begin
          e = exp_q.pop_front();
          check("ack_onehot", bus.ack, e[N+DW-1:DW]);
          check("rdata", bus.rdata, e[DW-1:0]);
          check("m_req_in_resp", bus.m_req, 0);
          glog.push_back(first_bit(bus.ack));
          pend = 0;
        end else begin
          check("ack_quiet", bus.ack, 0);
        end
        if (busy) begin
          check("m_req_busy", bus.m_req, 1);
          check("m_addr", bus.m_addr, e_addr);
          check("m_write", bus.m_write, e_write);
          check("m_wdata", bus.m_wdata, e_wdata);
          check("m_width", bus.m_width, e_width);
          check("m_extend", bus.m_extend, e_extend);
          if (bus.m_ack) begin
            exp_q.push_back({onehot(g), bus.m_rdata});
            pend = 1; busy = 0;
            free_from = cyc + 2;
          end
        end else begin
          if (!was_pend) check("m_req_idle", bus.m_req, 0);
          if (cyc >= free_from && bus.req != '0) begin
            g = pick(bus.req, ptr);
            e_addr   = bus.addr[g*AW +: AW];
            e_write  = bus.write[g];
            e_wdata  = bus.wdata[g*DW +: DW];
            e_width  = bus.width[g*2 +: 2];
            e_extend = bus.extend[g];
            ptr  = g;
            busy = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, n, c0, c3;
    int exp2[6];
    bus.req = '0; bus.addr = '0; bus.write = '0; bus.wdata = '0;
    bus.width = '0; bus.extend = '0; bus.m_ack = 1'b0; bus.m_rdata = '0;
    for (int i = 0; i < N; i++) begin hold[i] = 0; ack_cnt[i] = 0; end
    auto_resp = 1; resp_wait = 1;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_m_req", bus.m_req, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_write", bus.m_write, 0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_m_width", bus.m_width, 0);
    check("rst_m_extend", bus.m_extend, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_state", dbg_state, IDLE);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single read, port 1, memory acks one cycle after m_req
    issue(1, 32'h100, 1'b0, '0, WIDTH_WORD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t1_m_req_c1", bus.m_req, 1);
    check("t1_m_addr_c1", bus.m_addr, 32'h100);
    @(negedge clk);
    check("t1_ack_c2", bus.ack, 0);
    @(negedge clk);
    check("t1_ack_c3", bus.ack, 4'b0010);
    check("t1_rdata_c3", bus.rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_ack_c4", bus.ack, 0);
    wait_grants(1, 20, "t1");
    repeat (3) tick();

    // Contention: ports 1 and 3 requesting continuously
    base = glog.size();
    c3 = ack_cnt[3];
    hold[1] = 1; hold[3] = 1;
    issue(1, 32'h200, 1'b0, '0, WIDTH_WORD, 1'b0);
    issue(3, 32'h300, 1'b1, 32'hCAFE0003, WIDTH_HALF, 1'b1);
    n = 0;
    while (glog.size() < base + 6 && n < 200) begin
      tick();
      n++;
    end
    hold[1] = 0; hold[3] = 0;
    bus.req[1] = 1'b0; bus.req[3] = 1'b0;
    checks++;
    if (glog.size() < base + 6) begin
      errors++;
      $display("FAIL t2_timeout: grants %0d need %0d", glog.size() - base, 6);
    end
`ifdef MEM_ARB_RR_EN
    exp2 = '{3, 1, 3, 1, 3, 1};
`else
    exp2 = '{1, 1, 1, 1, 1, 1};
`endif
    for (int k = 0; k < 6; k++) check_grant($sformatf("t2_grant%0d", k), base + k, exp2[k]);
    repeat (4) tick();
`ifdef MEM_ARB_RR_EN
    check("t2_port3_acks", ack_cnt[3] - c3, 3);
`else
    check("t2_port3_starved", ack_cnt[3] - c3, 0);
`endif

    // Wrap: last grant 3, then ports 0 and 2 together
    base = glog.size();
    issue(3, 32'h3C, 1'b0, '0, WIDTH_BYTE, 1'b1);
    wait_grants(base + 1, 30, "t3a");
    tick();
    issue(0, 32'h10, 1'b0, '0, WIDTH_HALF, 1'b0);
    issue(2, 32'h20, 1'b1, 32'h0000_2222, WIDTH_WORD, 1'b0);
    wait_grants(base + 3, 60, "t3b");
    check_grant("t3_first", base, 3);
    check_grant("t3_wrap", base + 1, 0);
    check_grant("t3_third", base + 2, 2);
    repeat (3) tick();

    // Spurious m_ack in IDLE, then a word write from port 0
    auto_resp = 0;
    tick();
    bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0BAD0;
    tick();
    bus.m_ack = 1'b0;
    @(negedge clk);
    check("t4_spurious_ack", bus.ack, 0);
    check("t4_spurious_state", dbg_state, IDLE);
    tick();
    auto_resp = 1; resp_wait = 0;
    c0 = ack_cnt[0];
    base = glog.size();
    issue(0, 32'h40, 1'b1, 32'h12345678, WIDTH_WORD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t4_m_req", bus.m_req, 1);
    check("t4_m_write", bus.m_write, 1);
    check("t4_m_wdata", bus.m_wdata, 32'h12345678);
    check("t4_m_width", bus.m_width, WIDTH_WORD);
    check("t4_m_addr", bus.m_addr, 32'h40);
    @(negedge clk);
    check("t4_ack", bus.ack, 4'b0001);
    wait_grants(base + 1, 20, "t4");
    repeat (3) tick();
    check("t4_ack_count", ack_cnt[0] - c0, 1);

    // Reset while BUSY, then a stray m_ack
    resp_wait = 6;
    issue(2, 32'h2000, 1'b0, '0, WIDTH_BYTE, 1'b1);
    tick();
    tick();
    check("t5_busy_before_reset", bus.m_req, 1);
    rst = 1'b1; bus.req[2] = 1'b0; auto_resp = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_m_req_after_reset", bus.m_req, 0);
    check("t5_ack_after_reset", bus.ack, 0);
    check("t5_state_after_reset", dbg_state, IDLE);
    tick();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0BAD_F00D;
    tick();
    bus.m_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t5_no_ack%0d", k), bus.ack, 0);
    end

    // All four ports at once, mixed fields
    tick();
    auto_resp = 1; resp_wait = 2;
    base = glog.size();
    issue(0, 32'h1000, 1'b0, '0, WIDTH_BYTE, 1'b1);
    issue(1, 32'h1004, 1'b1, 32'hA1A1_0001, WIDTH_HALF, 1'b0);
    issue(2, 32'h1008, 1'b0, '0, WIDTH_WORD, 1'b0);
    issue(3, 32'h100C, 1'b1, 32'hB3B3_0003, WIDTH_BYTE, 1'b1);
    wait_grants(base + 4, 100, "t6");
    for (int k = 0; k < 4; k++) check_grant($sformatf("t6_grant%0d", k), base + k, k);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
